issue_scheduler: RTL and testbench

Per-cycle issue selector between the reservation station and the execute stage of the out-of-order core. Each cycle it chooses up to `N_WAY` ready RS entries for issue, subject to three limits: issue width, per-functional-unit caps, and a writeback (CDB) slot reservation table. The table guarantees that no more than `N_CDB` results reach writeback in any cycle. Grants are combinational, so the RS clears granted entries at the same clock edge.

---
 rtl/issue_scheduler_pkg.sv | 20 ++
 rtl/wb_resv_table.sv | 49 ++++
 rtl/issue_scheduler.sv | 123 ++++++++++++
 tb/tb_issue_scheduler.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// rtl/issue_scheduler_pkg.sv - shared types, latency constants and CDB budget helper
package issue_scheduler_pkg;

    typedef enum logic {
        FU_ALU = 1'b0,
        FU_MUL = 1'b1
    } fu_class_e;

    localparam int ALU_LAT = 1;
    localparam int MUL_LAT = 4;
    localparam int N_CDB   = 3;

    // True when one more writeback fits next to those already reserved and pending.
    function automatic logic can_reserve(input int unsigned resv,
                                         input int unsigned pending,
                                         input int unsigned n_cdb);
        return (resv + pending) < n_cdb;
    endfunction

endpackage

// File: rtl/wb_resv_table.sv
// rtl/wb_resv_table.sv - writeback slot reservation shift/count array
module wb_resv_table #(
    parameter int N_CDB   = issue_scheduler_pkg::N_CDB,
    parameter int MUL_LAT = issue_scheduler_pkg::MUL_LAT,
    parameter int CW      = $clog2(N_CDB) + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [MUL_LAT:1][CW-1:0]  inc,
    output logic [MUL_LAT:1][CW-1:0]  cnt
);

    logic [MUL_LAT:1][CW-1:0] cnt_q;
    logic [MUL_LAT:1][CW-1:0] cnt_d;
    logic [MUL_LAT:1][CW-1:0] full;

    // cnt_q[d] counts writebacks landing d cycles after the current one; this
    // cycle's grants of latency d join slot d and then everything shifts down.
    always_comb begin
        full  = '0;
        cnt_d = '0;
        for (int d = 1; d <= MUL_LAT; d++) begin
            full[d] = cnt_q[d] + inc[d];
        end
        for (int d = 1; d < MUL_LAT; d++) begin
            cnt_d[d] = full[d + 1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (!stall) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

    for (genvar d = 1; d <= MUL_LAT; d++) begin : g_inv
        a_cdb_budget: assert property (@(posedge clock) disable iff (!reset)
            (32'(full[d]) <= N_CDB) && (32'(cnt_q[d]) <= N_CDB));
    end

endmodule

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - round-robin issue selector with FU caps and CDB slot reservation
module issue_scheduler #(
    parameter int N_RS    = 16,
    parameter int N_WAY   = 3,
    parameter int N_CDB   = issue_scheduler_pkg::N_CDB,
    parameter int N_ALU   = 3,
    parameter int N_MUL   = 1,
    parameter int MUL_LAT = issue_scheduler_pkg::MUL_LAT
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [N_RS-1:0]                   rs_ready,
    input  logic [N_RS-1:0]                   rs_is_mul,
    input  logic                              ex_stall,
    input  logic                              flush,
    output logic [N_RS-1:0]                   issue_grant,
    output logic [N_WAY-1:0]                  issue_valid,
    output logic [N_WAY*$clog2(N_RS)-1:0]     issue_idx,
    output logic [$clog2(N_WAY):0]            issue_num,
    output logic [$clog2(N_CDB):0]            wb_resv_next
);

    import issue_scheduler_pkg::*;

    localparam int IW = $clog2(N_RS);
    localparam int NW = $clog2(N_WAY) + 1;
    localparam int CW = $clog2(N_CDB) + 1;

    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [MUL_LAT:1][CW-1:0]  resv_cnt;
    logic [MUL_LAT:1][CW-1:0]  resv_inc;
    logic                      blocked;

    int unsigned               n_way, n_alu, n_mul, pos, pend;
    logic [IW-1:0]             scan_idx, last_idx;
    logic                      any_grant, cap_ok;
    fu_class_e                 cls;
    logic [CW-1:0]             resv_sel;

    assign blocked = ex_stall | flush;

    // Unrolled greedy priority chain: a blocked entry is skipped, never stalls the scan.
    always_comb begin
        issue_grant = '0;
        issue_valid = '0;
        issue_idx   = '0;
        n_way       = 0;
        n_alu       = 0;
        n_mul       = 0;
        pos         = 0;
        pend        = 0;
        scan_idx    = '0;
        last_idx    = rr_ptr_q;
        any_grant   = 1'b0;
        cap_ok      = 1'b0;
        cls         = FU_ALU;
        resv_sel    = '0;
        for (int s = 0; s < N_RS; s++) begin
            pos      = (32'(rr_ptr_q) + s) % N_RS;
            scan_idx = IW'(pos);
            cls      = rs_is_mul[scan_idx] ? FU_MUL : FU_ALU;
            if (cls == FU_MUL) begin
                cap_ok   = n_mul < N_MUL;
                resv_sel = resv_cnt[MUL_LAT];
            end else begin
                cap_ok   = n_alu < N_ALU;
                resv_sel = resv_cnt[ALU_LAT];
            end
            if (MUL_LAT == ALU_LAT) begin
                pend = n_alu + n_mul;
            end else begin
                pend = (cls == FU_MUL) ? n_mul : n_alu;
            end
            if (!blocked && rs_ready[scan_idx] && (n_way < N_WAY) && cap_ok &&
                can_reserve(32'(resv_sel), pend, N_CDB)) begin
                issue_grant[scan_idx] = 1'b1;
                for (int k = 0; k < N_WAY; k++) begin
                    if (n_way == k) begin
                        issue_valid[k]          = 1'b1;
                        issue_idx[k*IW +: IW]   = scan_idx;
                    end
                end
                n_way     = n_way + 1;
                if (cls == FU_MUL) n_mul = n_mul + 1;
                else               n_alu = n_alu + 1;
                last_idx  = scan_idx;
                any_grant = 1'b1;
            end
        end
    end

    always_comb begin
        resv_inc           = '0;
        resv_inc[ALU_LAT]  = CW'(n_alu);
        resv_inc[MUL_LAT]  = resv_inc[MUL_LAT] + CW'(n_mul);
        rr_ptr_d           = any_grant ? IW'((32'(last_idx) + 1) % N_RS) : rr_ptr_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    wb_resv_table #(
        .N_CDB   (N_CDB),
        .MUL_LAT (MUL_LAT),
        .CW      (CW)
    ) u_wb_resv_table (
        .clock (clock),
        .reset (reset),
        .stall (ex_stall),
        .flush (flush),
        .inc   (resv_inc),
        .cnt   (resv_cnt)
    );

    assign issue_num    = NW'(n_way);
    assign wb_resv_next = resv_cnt[1];

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - directed self-checking bench for issue_scheduler
module tb_issue_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rs_ready = '0;
    logic [7:0] rs_is_mul = '0;
    logic       ex_stall = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] issue_grant;
    logic [2:0] issue_valid;
    logic [8:0] issue_idx;
    logic [2:0] issue_num;
    logic [2:0] wb_resv_next;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    issue_scheduler #(
        .N_RS(8), .N_WAY(3), .N_CDB(3), .N_ALU(3), .N_MUL(1), .MUL_LAT(4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rs_ready     (rs_ready),
        .rs_is_mul    (rs_is_mul),
        .ex_stall     (ex_stall),
        .flush        (flush),
        .issue_grant  (issue_grant),
        .issue_valid  (issue_valid),
        .issue_idx    (issue_idx),
        .issue_num    (issue_num),
        .wb_resv_next (wb_resv_next)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] rdy, input logic [7:0] mul, input logic st, input logic fl);
        @(negedge clock);
        rs_ready  = rdy;
        rs_is_mul = mul;
        ex_stall  = st;
        flush     = fl;
        #1;
    endtask

    task automatic expect_issue(input string tag, input logic [7:0] grant, input logic [2:0] num,
                                input logic [2:0] valid, input logic [8:0] idx);
        check({tag, "_grant"}, 32'(issue_grant), 32'(grant));
        check({tag, "_num"},   32'(issue_num),   32'(num));
        check({tag, "_valid"}, 32'(issue_valid), 32'(valid));
        check({tag, "_idx"},   32'(issue_idx),   32'(idx));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; rs_ready = '0; rs_is_mul = '0; ex_stall = 1'b0; flush = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        // reset state
        #1 reset = 1'b0;
        #1;
        check("rst_num",   32'(issue_num),    0);
        check("rst_grant", 32'(issue_grant),  0);
        check("rst_wb",    32'(wb_resv_next), 0);
        @(negedge clock);
        reset = 1'b1; rs_ready = 8'h01;
        #1;
        expect_issue("rst_first", 8'h01, 3'd1, 3'b001, 9'h000);

        // ALU burst and round robin
        do_reset();
        cyc(8'h1F, 8'h00, 1'b0, 1'b0);
        expect_issue("burst0", 8'h07, 3'd3, 3'b111, 9'h088);
        check("burst0_wb", 32'(wb_resv_next), 0);
        cyc(8'h18, 8'h00, 1'b0, 1'b0);
        expect_issue("burst1", 8'h18, 3'd2, 3'b011, 9'h023);

        // MUL cap of one
        do_reset();
        cyc(8'h0E, 8'h06, 1'b0, 1'b0);
        expect_issue("cap0", 8'h0A, 3'd2, 3'b011, 9'h019);
        cyc(8'h04, 8'h04, 1'b0, 1'b0);
        expect_issue("cap1", 8'h04, 3'd1, 3'b001, 9'h002);

        // CDB conflict between an old MUL and new ALUs
        do_reset();
        cyc(8'h01, 8'h01, 1'b0, 1'b0);
        expect_issue("cdb_mul", 8'h01, 3'd1, 3'b001, 9'h000);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        check("cdb_c1_wb", 32'(wb_resv_next), 0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        check("cdb_c2_wb", 32'(wb_resv_next), 0);
        cyc(8'h3E, 8'h00, 1'b0, 1'b0);
        check("cdb_c3_wb", 32'(wb_resv_next), 1);
        expect_issue("cdb_c3", 8'h06, 3'd2, 3'b011, 9'h011);
        cyc(8'h38, 8'h00, 1'b0, 1'b0);
        check("cdb_c4_wb", 32'(wb_resv_next), 0);
        expect_issue("cdb_c4", 8'h38, 3'd3, 3'b111, 9'h163);

        // flush discards the MUL reservation
        do_reset();
        cyc(8'h01, 8'h01, 1'b0, 1'b0);
        expect_issue("fl_mul", 8'h01, 3'd1, 3'b001, 9'h000);
        cyc(8'h02, 8'h00, 1'b1, 1'b1);
        expect_issue("fl_blk", 8'h00, 3'd0, 3'b000, 9'h000);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        cyc(8'h0E, 8'h00, 1'b0, 1'b0);
        check("fl_c3_wb", 32'(wb_resv_next), 0);
        expect_issue("fl_c3", 8'h0E, 3'd3, 3'b111, 9'h0D1);

        // stall freezes pointer and reservations; wrap-around scan
        do_reset();
        cyc(8'h01, 8'h01, 1'b0, 1'b0);
        expect_issue("st_mul", 8'h01, 3'd1, 3'b001, 9'h000);
        cyc(8'h81, 8'h00, 1'b1, 1'b0);
        expect_issue("st_s1", 8'h00, 3'd0, 3'b000, 9'h000);
        cyc(8'h81, 8'h00, 1'b1, 1'b0);
        expect_issue("st_s2", 8'h00, 3'd0, 3'b000, 9'h000);
        check("st_s2_wb", 32'(wb_resv_next), 0);
        cyc(8'h81, 8'h00, 1'b0, 1'b0);
        check("st_u1_wb", 32'(wb_resv_next), 0);
        expect_issue("st_wrap", 8'h81, 3'd2, 3'b011, 9'h007);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        check("st_u2_wb", 32'(wb_resv_next), 0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        check("st_u3_wb", 32'(wb_resv_next), 1);

        // asynchronous reset between clock edges
        #1 reset = 1'b0;
        #1;
        check("arst_wb", 32'(wb_resv_next), 0);
        #1 reset = 1'b1;
        cyc(8'h81, 8'h00, 1'b0, 1'b0);
        expect_issue("arst_ptr", 8'h81, 3'd2, 3'b011, 9'h038);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
